// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and parity helper.
// Used by uart_tx and intended for reuse by uart_rx.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] byte_i, input logic odd_i);
    return (^byte_i) ^ odd_i;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps at CLKS_PER_BIT-1 and restarts on a synchronous clear.
// pre_tick_o flags the cycle before the wrap so callers can act one cycle early.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk_i,
  input  logic srst_ni,
  input  logic clr_i,
  output logic bit_tick_o,
  output logic pre_tick_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntPre  = CntW'(CLKS_PER_BIT - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_tick_o = (cnt_q == CntLast);
  assign pre_tick_o = (cnt_q == CntPre);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, 1 or 2 stop bits, registered outputs.
// Define UART_TX_PARITY_EN to add a parity bit (even/odd chosen by PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_RATE   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data_val,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned ClksPerBit = CLK_RATE / BAUD_RATE;
  localparam int unsigned BitCntW    = $clog2(DATA_BITS);
  localparam logic [BitCntW-1:0] BitLast  = BitCntW'(DATA_BITS - 1);
  localparam logic               StopLast = 1'(STOP_BITS - 1);

  uart_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 baud_clr;
  logic                 bit_tick;
  logic                 pre_tick;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(ClksPerBit)
  ) u_baud_gen (
    .clk_i     (clk),
    .srst_ni   (reset_n),
    .clr_i     (baud_clr),
    .bit_tick_o(bit_tick),
    .pre_tick_o(pre_tick)
  );

  assign ready = ready_q;
  assign tx    = tx_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    baud_clr   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (ready_q && data_val) begin
          state_d    = START;
          shift_d    = data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          baud_clr   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = parity_bit(data, PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        // Leave one cycle early: the accept edge in IDLE closes the last stop bit, so
        // back-to-back frames carry no idle gap while every bit still lasts a full period.
        if ((stop_cnt_q == StopLast) && pre_tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (bit_tick) begin
          stop_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
